hazard_scoreboard: RTL

Parametrised scoreboard-based hazard and forwarding unit for the in-order MIPS pipeline. It generalises the fixed 5-stage hazard unit to any depth and to per-instruction result latency. It tracks every in-flight destination register with countdown counters, stalls the issue (decode) stage on RAW/WAW hazards and multicycle-unit occupancy, and produces per-operand forwarding selects. It sits beside the decode stage and is driven by the datapath's stall and flush controls.

---
 rtl/hazard_scoreboard_if.sv | 32 +++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side issue/control bundle between the pipeline and the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int LAT_W = 4,
  parameter int SEL_W = 3
);
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rs;
  logic [REG_AW-1:0] issue_rt;
  logic              issue_rs_used;
  logic              issue_rt_used;
  logic              issue_wen;
  logic [REG_AW-1:0] issue_dst;
  logic [LAT_W-1:0]  issue_lat;
  logic              issue_multi;
  logic              mc_done;
  logic              ext_stall;
  logic              flush;
  logic              stall_issue;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used, issue_wen,
           issue_dst, issue_lat, issue_multi, mc_done, ext_stall, flush,
    input  stall_issue, fwd_a_sel, fwd_b_sel
  );
  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used, issue_wen,
           issue_dst, issue_lat, issue_multi, mc_done, ext_stall, flush,
    output stall_issue, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: countdown scoreboard for RAW/WAW/multicycle stalls and forwarding selects; HAZARD_STAT_EN adds stall/mc occupancy counters
module hazard_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int REG_AW = 5,
  parameter int STAGES = 5,
  parameter int LAT_W = 4,
  parameter int FLUSH_AGE = 2,
  parameter int SEL_W = 3
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave sb
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0] stat_stall_cnt,
  output logic [31:0] stat_mc_cnt
`endif
);
  localparam logic [SEL_W-1:0] AGE_INIT = SEL_W'(STAGES - 2);
  localparam logic [SEL_W-1:0] KILL_AGE = SEL_W'(FLUSH_AGE);

  logic [REG_NUM-1:0] pend_q, pend_d, mc_q, mc_d;
  logic [LAT_W-1:0]   rdy_q [REG_NUM];
  logic [LAT_W-1:0]   rdy_d [REG_NUM];
  logic [SEL_W-1:0]   age_q [REG_NUM];
  logic [SEL_W-1:0]   age_d [REG_NUM];
  logic adv, mc_any, haz_a, haz_b, waw, accept, wr_en;

  // hazard detection and forwarding selects from registered state plus current decode inputs
  always_comb begin
    adv = ~sb.ext_stall;
    mc_any = |mc_q;
    haz_a = sb.issue_rs_used & (sb.issue_rs != '0) & pend_q[sb.issue_rs] &
            ((rdy_q[sb.issue_rs] != '0) | mc_q[sb.issue_rs]);
    haz_b = sb.issue_rt_used & (sb.issue_rt != '0) & pend_q[sb.issue_rt] &
            ((rdy_q[sb.issue_rt] != '0) | mc_q[sb.issue_rt]);
    waw = sb.issue_wen & (sb.issue_dst != '0) & pend_q[sb.issue_dst];
    sb.stall_issue = sb.issue_valid & ~sb.flush & (haz_a | haz_b | waw | (sb.issue_multi & mc_any));
    accept = sb.issue_valid & ~sb.stall_issue & adv & ~sb.flush;
    wr_en = accept & sb.issue_wen & (sb.issue_dst != '0);
    sb.fwd_a_sel = (sb.issue_rs_used & (sb.issue_rs != '0) & pend_q[sb.issue_rs] &
                    (rdy_q[sb.issue_rs] == '0) & ~mc_q[sb.issue_rs]) ? age_q[sb.issue_rs] : '0;
    sb.fwd_b_sel = (sb.issue_rt_used & (sb.issue_rt != '0) & pend_q[sb.issue_rt] &
                    (rdy_q[sb.issue_rt] == '0) & ~mc_q[sb.issue_rt]) ? age_q[sb.issue_rt] : '0;
  end

  // per-register update: new issue, flush kill of young entries, or countdown toward writeback
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      pend_d[r] = pend_q[r];
      mc_d[r] = mc_q[r] & ~sb.mc_done;
      rdy_d[r] = rdy_q[r];
      age_d[r] = age_q[r];
      if (wr_en && sb.issue_dst == REG_AW'(r)) begin
        pend_d[r] = 1'b1;
        mc_d[r] = sb.issue_multi;
        rdy_d[r] = sb.issue_lat;
        age_d[r] = AGE_INIT;
      end else if (sb.flush && age_q[r] >= KILL_AGE) begin
        pend_d[r] = 1'b0;
        mc_d[r] = 1'b0;
      end else if (pend_q[r] && adv && !mc_q[r]) begin
        rdy_d[r] = rdy_q[r] - LAT_W'(rdy_q[r] != '0);
        age_d[r] = age_q[r] - SEL_W'(1);
        pend_d[r] = age_q[r] != SEL_W'(1);
      end
    end
  end

  // scoreboard state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      mc_q <= '0;
      rdy_q <= '{default: '0};
      age_q <= '{default: '0};
    end else begin
      pend_q <= pend_d;
      mc_q <= mc_d;
      rdy_q <= rdy_d;
      age_q <= age_d;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] stat_stall_q, stat_mc_q;

  // free-running occupancy counters, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_q <= '0;
      stat_mc_q <= '0;
    end else begin
      stat_stall_q <= stat_stall_q + 32'(sb.stall_issue);
      stat_mc_q <= stat_mc_q + 32'(mc_any);
    end
  end

  assign stat_stall_cnt = stat_stall_q;
  assign stat_mc_cnt = stat_mc_q;
`endif
endmodule
